// File: rtl/dft_pkg.sv
// Shared constants, widths and state encoding for the 16-point bin-1 DFT accumulator.
package dft_pkg;

   localparam int LOG2N      = 4;
   localparam int N          = 1 << LOG2N;
   localparam int DATA_W_DEF = 16;
   localparam int TW_W_DEF   = 16;
   localparam int ACC_W_DEF  = 36;

   localparam logic [15:0] TW_ONE = 16'h7FFF;

   localparam logic [1:0] QUAD_0 = 2'd0;
   localparam logic [1:0] QUAD_1 = 2'd1;
   localparam logic [1:0] QUAD_2 = 2'd2;
   localparam logic [1:0] QUAD_3 = 2'd3;

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

endpackage

// File: rtl/dft_bin_accum_if.sv
// Sample-in / bin-out streaming handshakes of dft_bin_accum; m_mag exists only with DFT_BIN_MAG_EN.
interface dft_bin_accum_if
   import dft_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
);
   logic signed [DATA_W-1:0] s_data;
   logic                     s_valid;
   logic                     s_ready;
   logic signed [ACC_W-1:0]  m_re;
   logic signed [ACC_W-1:0]  m_im;
   logic                     m_valid;
   logic                     m_ready;
`ifdef DFT_BIN_MAG_EN
   logic [ACC_W-1:0]         m_mag;

   modport master (output s_data, s_valid, m_ready,
                   input  s_ready, m_re, m_im, m_valid, m_mag);
   modport slave  (input  s_data, s_valid, m_ready,
                   output s_ready, m_re, m_im, m_valid, m_mag);
`else
   modport master (output s_data, s_valid, m_ready,
                   input  s_ready, m_re, m_im, m_valid);
   modport slave  (input  s_data, s_valid, m_ready,
                   output s_ready, m_re, m_im, m_valid);
`endif
endinterface

// File: rtl/dft_twiddle_rotate.sv
// Expands the first-quadrant twiddle (c,s) to any of the four quadrants; one register stage.
module dft_twiddle_rotate
   import dft_pkg::*;
#(
   parameter int TW_W = TW_W_DEF
)(
   input  logic                   clk,
   input  logic [1:0]             q,
   input  logic [1:0]             m,
   input  logic signed [TW_W-1:0] tw_re,
   input  logic signed [TW_W-1:0] tw_im,
   output logic signed [TW_W-1:0] cos_p1,
   output logic signed [TW_W-1:0] sin_p1
);

   localparam logic signed [TW_W-1:0] ONE = {1'b0, {(TW_W-1){1'b1}}};

   logic signed [TW_W-1:0] c;
   logic signed [TW_W-1:0] s;
   logic signed [TW_W-1:0] cos_n;
   logic signed [TW_W-1:0] sin_n;

   // m==0 is the quadrant axis itself, which the ROM does not store.
   always_comb begin
      c     = (m == 2'd0) ? ONE : tw_re;
      s     = (m == 2'd0) ? '0  : tw_im;
      cos_n = c;
      sin_n = s;
      case (q)
         QUAD_1: begin cos_n = -s; sin_n =  c; end
         QUAD_2: begin cos_n = -c; sin_n = -s; end
         QUAD_3: begin cos_n =  s; sin_n = -c; end
         default: ;
      endcase
   end

   // Stage 1
   always_ff @(posedge clk) begin
      cos_p1 <= cos_n;
      sin_p1 <= sin_n;
   end

endmodule

// File: rtl/dft_bin_accum.sv
// 16-sample bin-1 DFT accumulator fed by a 3-entry twiddle ROM.
// Optional DFT_BIN_MAG_EN adds an alpha-max-beta-min magnitude output one cycle later.
module dft_bin_accum
   import dft_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int TW_W   = TW_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int LOG2N  = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   dft_bin_accum_if.slave         bus,
   output logic [1:0]             tw_raddr,
   output logic                   tw_rd,
   input  logic signed [TW_W-1:0] tw_re,
   input  logic signed [TW_W-1:0] tw_im
);

   localparam int PROD_W = DATA_W + TW_W;
`ifdef DFT_BIN_MAG_EN
   localparam logic [1:0] DRAIN_LAST = 2'd2;
`else
   localparam logic [1:0] DRAIN_LAST = 2'd1;
`endif

   function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
      return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
   endfunction

   state_t                   state;
   logic [LOG2N-1:0]         n_cnt;
   logic [1:0]               drain_cnt;
   logic                     s_ready_r;
   logic                     m_valid_r;
   logic                     accept;
   logic                     vld_p0;
   logic                     vld_p1;
   logic signed [DATA_W-1:0] x_p0;
   logic signed [DATA_W-1:0] x_p1;
   logic [1:0]               q_p0;
   logic [1:0]               m_p0;
   logic signed [TW_W-1:0]   cos_p1;
   logic signed [TW_W-1:0]   sin_p1;
   logic signed [PROD_W-1:0] prod_re;
   logic signed [PROD_W-1:0] prod_im;
   logic signed [ACC_W-1:0]  acc_re;
   logic signed [ACC_W-1:0]  acc_im;

   assign accept   = bus.s_valid & s_ready_r;
   assign tw_rd    = accept & (n_cnt[1:0] != 2'd0);
   assign tw_raddr = tw_rd ? (n_cnt[1:0] - 2'd1) : 2'd0;

   // Stage 0
   always_ff @(posedge clk) begin
      if (accept) begin
         x_p0 <= bus.s_data;
         q_p0 <= n_cnt[LOG2N-1 -: 2];
         m_p0 <= n_cnt[1:0];
      end
   end

   // Stage 1
   dft_twiddle_rotate #(.TW_W(TW_W)) u_rot (
      .clk    (clk),
      .q      (q_p0),
      .m      (m_p0),
      .tw_re  (tw_re),
      .tw_im  (tw_im),
      .cos_p1 (cos_p1),
      .sin_p1 (sin_p1)
   );

   always_ff @(posedge clk) begin
      x_p1 <= x_p0;
   end

   // Stage 2
   assign prod_re = x_p1 * cos_p1;
   assign prod_im = x_p1 * sin_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         n_cnt     <= '0;
         drain_cnt <= '0;
         s_ready_r <= 1'b0;
         m_valid_r <= 1'b0;
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         acc_re    <= '0;
         acc_im    <= '0;
      end else if (clr) begin
         state     <= IDLE;
         s_ready_r <= 1'b0;
         m_valid_r <= 1'b0;
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
      end else begin
         vld_p0 <= accept;
         vld_p1 <= vld_p0;
         if (state == IDLE) begin
            acc_re <= '0;
            acc_im <= '0;
         end else if (vld_p1) begin
            acc_re <= acc_re + sext_prod(prod_re);
            acc_im <= acc_im - sext_prod(prod_im);
         end
         case (state)
            IDLE: begin
               state     <= ACCUM;
               n_cnt     <= '0;
               s_ready_r <= 1'b1;
            end
            ACCUM: begin
               if (accept) begin
                  n_cnt <= n_cnt + 1'b1;
                  if (&n_cnt) begin
                     state     <= DRAIN;
                     s_ready_r <= 1'b0;
                     drain_cnt <= '0;
                  end
               end
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 2'd1;
               if (drain_cnt == DRAIN_LAST) begin
                  state     <= OUT;
                  m_valid_r <= 1'b1;
               end
            end
            OUT: begin
               if (bus.m_ready) begin
                  state     <= IDLE;
                  m_valid_r <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DFT_BIN_MAG_EN
   function automatic logic [ACC_W-1:0] abs_acc(input logic signed [ACC_W-1:0] v);
      return v[ACC_W-1] ? -v : v;
   endfunction

   function automatic logic [ACC_W-1:0] mag_est(input logic signed [ACC_W-1:0] re,
                                                input logic signed [ACC_W-1:0] im);
      logic [ACC_W-1:0] a;
      logic [ACC_W-1:0] b;
      a = abs_acc(re);
      b = abs_acc(im);
      return (a > b) ? (a + (b >> 1)) : (b + (a >> 1));
   endfunction

   // Magnitude stage: accumulators settle one cycle before this register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.m_mag <= '0;
      end else begin
         bus.m_mag <= mag_est(acc_re, acc_im);
      end
   end
`endif

   assign bus.s_ready = s_ready_r;
   assign bus.m_valid = m_valid_r;
   assign bus.m_re    = acc_re;
   assign bus.m_im    = acc_im;

endmodule

// File: tb/tb_dft_bin_accum.sv
// Directed bench for dft_bin_accum with a behavioural 3-entry twiddle ROM.
module tb_dft_bin_accum;
   import dft_pkg::*;

   localparam int DW = 16;
   localparam int TW = 16;
   localparam int AW = 36;
`ifdef DFT_BIN_MAG_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 3;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 clr = 1'b0;
   logic [1:0]           tw_raddr;
   logic                 tw_rd;
   logic signed [TW-1:0] tw_re = '0;
   logic signed [TW-1:0] tw_im = '0;

   dft_bin_accum_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

   dft_bin_accum #(.DATA_W(DW), .TW_W(TW), .ACC_W(AW), .LOG2N(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .bus      (bus.slave),
      .tw_raddr (tw_raddr),
      .tw_rd    (tw_rd),
      .tw_re    (tw_re),
      .tw_im    (tw_im)
   );

   always #5 clk = ~clk;

   // w1..w3 = cos/sin of 2*pi*k/16 in Q1.15
   always @(posedge clk) begin
      if (tw_rd) begin
         case (tw_raddr)
            2'd0:    begin tw_re <= 16'sd30274; tw_im <= 16'sd12540; end
            2'd1:    begin tw_re <= 16'sd23170; tw_im <= 16'sd23170; end
            2'd2:    begin tw_re <= 16'sd12540; tw_im <= 16'sd30274; end
            default: begin tw_re <= 16'sd0;     tw_im <= 16'sd0;     end
         endcase
      end
   end

   int total = 0;
   int bad   = 0;
   logic signed [DW-1:0] blk [16];
   int cos_t [16] = '{32767, 30274, 23170, 12540, 0, -12540, -23170, -30274,
                      -32767, -30274, -23170, -12540, 0, 12540, 23170, 30274};
   int sin_t [16] = '{0, 12540, 23170, 30274, 32767, 30274, 23170, 12540,
                      0, -12540, -23170, -30274, -32767, -30274, -23170, -12540};

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_impulse(input int idx, input int val);
      for (int i = 0; i < 16; i++) blk[i] = '0;
      blk[idx] = DW'(val);
   endtask

   task automatic model(output longint er, output longint ei);
      er = 0;
      ei = 0;
      for (int i = 0; i < 16; i++) begin
         er = er + longint'(blk[i]) * longint'(cos_t[i]);
         ei = ei - longint'(blk[i]) * longint'(sin_t[i]);
      end
   endtask

   // Feeds blk[0..cnt-1]; returns on the negedge after the last accept with s_valid low.
   task automatic send_block(input int cnt, input logic [15:0] gaps);
      int i = 0;
      int guard = 0;
      while (i < cnt && guard < 500) begin
         @(negedge clk);
         guard++;
         if (gaps[guard % 16]) begin
            bus.s_valid = 1'b0;
         end else begin
            bus.s_valid = 1'b1;
            bus.s_data  = blk[i];
            #1;
            if (bus.s_ready) begin
               chk("tw_rd", {63'd0, tw_rd}, {63'd0, (i % 4) != 0});
               if (i % 4 != 0) chk("tw_raddr", {62'd0, tw_raddr}, 64'(i % 4 - 1));
               i++;
            end
         end
      end
      if (i < cnt) chk("send_timeout", 64'(i), 64'(cnt));
      @(negedge clk);
      bus.s_valid = 1'b0;
   endtask

   task automatic take_result(input string tag, input longint er, input longint ei, input int hold);
      int lat = 1;
      logic stable = 1'b1;
      logic signed [AW-1:0] re0;
      while (!bus.m_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(LAT));
      re0 = bus.m_re;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         if (!(bus.m_valid === 1'b1 && bus.m_re === re0 && bus.s_ready === 1'b0)) stable = 1'b0;
      end
      if (hold > 0) chk({tag, "_hold_stable"}, {63'd0, stable}, 64'd1);
      chk({tag, "_re"}, 64'(bus.m_re), er);
      chk({tag, "_im"}, 64'(bus.m_im), ei);
`ifdef DFT_BIN_MAG_EN
      begin
         longint a, b, mg;
         a = (er < 0) ? -er : er;
         b = (ei < 0) ? -ei : ei;
         mg = (a > b) ? a + (b >>> 1) : b + (a >>> 1);
         chk({tag, "_mag"}, {28'd0, bus.m_mag}, mg);
      end
`endif
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
      chk({tag, "_mvalid_drop"}, {63'd0, bus.m_valid}, 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint er, ei;
      logic ok;
      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.m_ready = 1'b0;

      #12;
      chk("rst_s_ready",  {63'd0, bus.s_ready}, 64'd0);
      chk("rst_m_valid",  {63'd0, bus.m_valid}, 64'd0);
      chk("rst_m_re",     64'(bus.m_re), 64'd0);
      chk("rst_m_im",     64'(bus.m_im), 64'd0);
      chk("rst_tw_rd",    {63'd0, tw_rd}, 64'd0);
      chk("rst_tw_raddr", {62'd0, tw_raddr}, 64'd0);
      @(negedge clk);
      rst = 1'b1;

      set_impulse(0, 1000);
      send_block(16, 16'h0000);
      take_result("imp0", 64'sd32767000, 64'sd0, 0);

      set_impulse(4, 1000);
      send_block(16, 16'h0000);
      take_result("imp4", 64'sd0, -64'sd32767000, 0);

      set_impulse(1, 1000);
      send_block(16, 16'h0000);
      take_result("imp1", 64'sd30274000, -64'sd12540000, 0);

      for (int i = 0; i < 16; i++) blk[i] = 16'sd1000;
      send_block(16, 16'h0000);
      take_result("dc", 64'sd0, 64'sd0, 0);

      set_impulse(1, 1000);
      send_block(16, 16'b0110_0010_1001_0100);
      take_result("imp1_gaps", 64'sd30274000, -64'sd12540000, 0);

      set_impulse(0, 1000);
      send_block(16, 16'h0000);
      take_result("backpressure", 64'sd32767000, 64'sd0, 10);

      for (int i = 0; i < 16; i++) blk[i] = DW'(i * 1234 - 9000);
      model(er, ei);
      send_block(16, 16'h0000);
      take_result("b2b_a", er, ei, 0);
      for (int i = 0; i < 16; i++) blk[i] = (i % 2 == 1) ? -16'sd32768 : 16'sd32767;
      model(er, ei);
      send_block(16, 16'h0000);
      take_result("b2b_b", er, ei, 0);

      for (int i = 0; i < 16; i++) blk[i] = 16'sd5000;
      send_block(7, 16'h0000);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_s_ready", {63'd0, bus.s_ready}, 64'd0);
      set_impulse(0, 1000);
      send_block(16, 16'h0000);
      take_result("after_clr", 64'sd32767000, 64'sd0, 0);

      set_impulse(4, 1000);
      send_block(16, 16'h0000);
      while (!bus.m_valid) @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("clr_out_m_valid", {63'd0, bus.m_valid}, 64'd0);

      set_impulse(1, 1000);
      send_block(16, 16'h0000);
      rst = 1'b0;
      #1;
      chk("drain_rst_m_valid", {63'd0, bus.m_valid}, 64'd0);
      chk("drain_rst_s_ready", {63'd0, bus.s_ready}, 64'd0);
      chk("drain_rst_m_re",    64'(bus.m_re), 64'd0);
      chk("drain_rst_m_im",    64'(bus.m_im), 64'd0);
      chk("drain_rst_tw_rd",   {63'd0, tw_rd}, 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (bus.m_valid !== 1'b0) ok = 1'b0;
      end
      chk("drain_rst_no_result", {63'd0, ok}, 64'd1);
      set_impulse(0, 1000);
      send_block(16, 16'h0000);
      take_result("after_rst", 64'sd32767000, 64'sd0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
